// File: rtl/layer_color_mapper.sv
// Priority-resolving layer colour mapper with a double-buffered palette committed at frame start.
// Define LAYER_BLINK_EN to build the per-layer blink counter and hit masking.
module layer_color_mapper #(
  parameter int unsigned N_LAYERS     = 4,
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   pixel_valid,
  input  logic [N_LAYERS-1:0]    layer_hit,
  input  logic                   frame_start,
  input  logic [N_LAYERS-1:0]    blink_en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [3:0]             wr_idx,
  input  logic [3*COLOR_W-1:0]   wr_rgb,
  output logic                   out_valid,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B
);

  localparam int unsigned RgbW    = 3 * COLOR_W;
  localparam int unsigned Entries = 16;
  localparam logic [3:0]  BgIdx   = 4'(N_LAYERS);

  typedef logic [RgbW-1:0] rgb_t;

  // Reset colours are 8-bit values, left-aligned into the configured channel width.
  function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] c);
    logic [31:0] wide;
    wide = {24'd0, c};
    if (COLOR_W >= 8) wide = wide << (COLOR_W - 8);
    else              wide = wide >> (8 - COLOR_W);
    return wide[COLOR_W-1:0];
  endfunction

  function automatic rgb_t default_entry(input int unsigned idx);
    logic [23:0] c8;
    if (idx == N_LAYERS) begin
      c8 = 24'hFFFFFF;
    end else begin
      case (idx)
        0:       c8 = 24'hFFFF00;
        1:       c8 = 24'h87CEEB;
        2:       c8 = 24'hF0828C;
        default: c8 = 24'h000000;
      endcase
    end
    return {scale8(c8[23:16]), scale8(c8[15:8]), scale8(c8[7:0])};
  endfunction

  rgb_t shadow_q [Entries];
  rgb_t active_q [Entries];

  logic wr_fire;

  assign wr_ready = ~frame_start;
  assign wr_fire  = wr_valid & wr_ready;

  // Entries above the background index are never written and stay constant.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        shadow_q[i] <= default_entry(i);
        active_q[i] <= default_entry(i);
      end
    end else begin
      if (frame_start) begin
        for (int unsigned i = 0; i < Entries; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (wr_fire && (wr_idx <= BgIdx)) begin
        shadow_q[wr_idx] <= wr_rgb;
      end
    end
  end

  logic [N_LAYERS-1:0] hit_mask;

`ifdef LAYER_BLINK_EN
  localparam logic [7:0] LastFrame = 8'(BLINK_FRAMES - 1);

  logic [7:0] frame_cnt_q;
  logic       blink_phase_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt_q == LastFrame) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign hit_mask = blink_phase_q ? blink_en : '0;
`else
  logic unused_blink_en;
  assign unused_blink_en = ^blink_en;
  assign hit_mask        = '0;
`endif

  logic [N_LAYERS-1:0] masked_hit;
  logic [3:0]          sel_idx;

  assign masked_hit = layer_hit & ~hit_mask;

  // Scan from lowest priority upward so the lowest set index wins.
  always_comb begin
    sel_idx = BgIdx;
    for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
      if (masked_hit[i]) sel_idx = 4'(i);
    end
  end

  logic       s1_valid_q;
  logic [3:0] s1_idx_q;
  rgb_t       rgb_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      out_valid  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      s1_valid_q <= pixel_valid;
      s1_idx_q   <= sel_idx;
      out_valid  <= s1_valid_q;
      rgb_q      <= s1_valid_q ? active_q[s1_idx_q] : '0;
    end
  end

  assign VGA_R = rgb_q[RgbW-1 -: COLOR_W];
  assign VGA_G = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B = rgb_q[COLOR_W-1:0];

endmodule

// File: doc/layer_color_mapper.md
# layer_color_mapper

Pipelined, parametrised successor to the single-cycle colour mapper. Takes N_LAYERS per-pixel layer-hit flags from the sprite/object generators, resolves them by fixed priority, and looks up a runtime-writable palette. The palette is double-buffered and committed at frame start, so colour changes never tear mid-frame. Optional per-layer blink drives the VGA RGB outputs; the block sits between the object generators and the VGA controller.

## Interface
- N_LAYERS, 4, number of object layers; legal range 1–15; bit 0 has the highest priority.
- COLOR_W, 8, bits per colour channel; legal range 4–12.
- BLINK_FRAMES, 30, frames per blink half-period; legal range 1–255.
- Clk  in  1  pixel clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- pixel_valid  in  1  layer_hit is valid this cycle (active video).
- layer_hit  in  N_LAYERS  per-layer hit flags for the current pixel.
- frame_start  in  1  one-cycle pulse, issued during vertical blanking.
- blink_en  in  N_LAYERS  per-layer blink enable; static or quasi-static.
- wr_valid  in  1  palette write request.
- wr_ready  out  1  palette write accepted when wr_valid && wr_ready.
- wr_idx  in  4  palette entry; 0..N_LAYERS-1 = layers, N_LAYERS = background.
- wr_rgb  in  3*COLOR_W  {R,G,B} value to write.
- out_valid  out  1  VGA_R/G/B correspond to a valid pixel.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour.

## Operation
- Palette: N_LAYERS+1 entries, held in two copies:
  - shadow: written by the write port.
  - active: read by the pixel pipeline.
- Palette reset values, 8-bit left-aligned. For COLOR_W>8, LSBs are zero-padded; for COLOR_W<8, LSBs are truncated.
  - layer0 = FF/FF/00.
  - layer1 = 87/CE/EB.
  - layer2 = F0/82/8C.
  - layers 3+ = 00/00/00.
  - background = FF/FF/FF.
  - Both copies reset identically.
- Write port:
  - wr_ready = ~frame_start.
  - An accepted write updates the shadow entry at the next edge.
  - A write with wr_idx > N_LAYERS is accepted and discarded.
- Commit: on an edge where frame_start=1, active ← shadow, all entries at once.
- Blink:
  - 8-bit frame counter increments on frame_start.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 on the next frame_start and toggles blink_phase.
  - When blink_phase=1, every layer with blink_en set is masked from layer_hit.
  - A masked pixel falls through to the next lower-priority hit, or to background if none.
- Priority: lowest set index of the masked hit vector wins; an all-zero vector selects background.
- Stage 1 (edge after sample): registers pixel_valid and the selected palette index (4 bits).
- Stage 2: registers out_valid and the active palette entry at the stage-1 index.
- When out_valid=0, VGA_R/G/B are driven to 0 (blanking black).
- Reset values:
  - out_valid=0, VGA_R/G/B=0.
  - wr_ready=1 (unless frame_start is high).
  - blink_phase=0, frame counter=0, pipeline registers=0.

## Timing
- Latency: 2 cycles from pixel_valid/layer_hit to out_valid/VGA_*; throughput is 1 pixel per cycle.
- Blink mask uses the blink_phase register value in the sample cycle.
- Stage 2 reads the active palette in its cycle. A frame_start at edge t therefore affects stage-2 output from cycle t+1 onward.
- frame_start during active video is not supported; pixels in flight may then mix old and new palettes.
- wr_valid together with frame_start is stalled (wr_ready=0); the requester holds the request.
- Back-to-back writes to the same entry: last accepted write wins.
- Reset assertion mid-frame:
  - Clears the pipeline and outputs immediately (asynchronous).
  - Restores the default palette and clears blink state.
  - First valid output appears 2 cycles after the first pixel_valid following release.

## Configuration
- LAYER_BLINK_EN defined: the blink counter, blink_phase and masking are built as described.
- LAYER_BLINK_EN undefined:
  - No blink logic is built; blink_en is ignored.
  - Layer hits are never masked.
  - All other behaviour is unchanged.

## Test plan
- Reset, then pixel_valid=1, layer_hit=4'b0110 → 2 cycles later out_valid=1, RGB=87/CE/EB; with layer_hit=0 → FF/FF/FF.
- Write idx1=12/34/56 mid-frame → output for layer1 stays 87/CE/EB until frame_start, then 12/34/56.
- wr_valid=1 in the same cycle as frame_start → wr_ready=0, write taken next cycle, committed only at the following frame_start.
- BLINK_FRAMES=2, blink_en=4'b0001, layer_hit=4'b0011 → phase pattern 0,0,1,1 per frame; colours FF/FF/00, FF/FF/00, 87/CE/EB, 87/CE/EB (layer 0 masked when phase=1). Without LAYER_BLINK_EN the output is always FF/FF/00.
- Write wr_idx=7 with N_LAYERS=4 → accepted (wr_ready=1), no palette change after commit.
- Assert Reset_n low mid-stream after palette writes → out_valid=0 and RGB=0 at once; after release the default palette is restored.
